// File: rtl/mem_unit_pipelined.sv
// Parametrised single-port data memory with valid/ready requests, RD_LAT-deep in-order read
// responses, an out-of-range check and a clear sweep. Define MEM_PARITY_EN to store and check even parity.
module mem_unit_pipelined #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              init_start,
    output logic              init_busy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              par_err
);

`ifdef MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  cnt;
    logic               last_clear;
    logic               accept;
    logic               in_range;
    logic               rd_go;
    logic               wr_go;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [WORD_W-1:0]  rd_pipe [RD_LAT];
    logic [RD_LAT-1:0]  vld_pipe;
    logic [RD_LAT-1:0]  err_pipe;
    logic [WORD_W-1:0]  rd_word;
    logic               err_last;

    function automatic logic [WORD_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign last_clear = (cnt == ADDR_W'(DEPTH - 1));
    assign accept     = req_valid & req_ready;
    // Compare at 32 bits so DEPTH == 2**ADDR_W neither wraps nor truncates.
    assign in_range   = (32'(req_addr) < 32'(DEPTH));
    assign rd_go      = accept & ~req_write;
    assign wr_go      = accept & req_write & in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT && !last_clear) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (last_clear) state_nxt = RUN;
            RUN:     if (init_start) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        init_busy = 1'b1;
        req_ready = 1'b0;
        if (state == RUN) begin
            init_busy = 1'b0;
            req_ready = 1'b1;
        end
    end

    // The array and the data pipeline are not reset; the outputs are qualified by vld_pipe instead.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (wr_go) begin
            mem[req_addr] <= encode(req_wdata);
        end
        if (rd_go && in_range) begin
            rd_pipe[0] <= mem[req_addr];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_go;
            err_pipe[0] <= rd_go & ~in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
            end
        end
    end

    assign rd_word   = rd_pipe[RD_LAT-1];
    assign err_last  = err_pipe[RD_LAT-1];
    assign rsp_valid = vld_pipe[RD_LAT-1];
    assign rsp_err   = rsp_valid & err_last;
    assign rsp_rdata = (rsp_valid && !err_last) ? rd_word[DATA_W-1:0] : '0;

`ifdef MEM_PARITY_EN
    assign par_err   = rsp_valid & ~err_last & (^rd_word);
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_unit_pipelined.sv
// Directed bench for mem_unit_pipelined: instance u_a uses DEPTH=256/RD_LAT=1,
// instance u_b uses DEPTH=200/RD_LAT=3; both share clock and reset.
module tb_mem_unit_pipelined;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_req_valid = 1'b0, a_req_write = 1'b0, a_init_start = 1'b0;
    logic [7:0] a_req_addr = '0, a_req_wdata = '0;
    logic       a_req_ready, a_init_busy, a_rsp_valid, a_rsp_err, a_par_err;
    logic [7:0] a_rsp_rdata;

    logic       b_req_valid = 1'b0, b_req_write = 1'b0, b_init_start = 1'b0;
    logic [7:0] b_req_addr = '0, b_req_wdata = '0;
    logic       b_req_ready, b_init_busy, b_rsp_valid, b_rsp_err, b_par_err;
    logic [7:0] b_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_unit_pipelined #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .init_start(a_init_start), .init_busy(a_init_busy),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .par_err(a_par_err)
    );

    mem_unit_pipelined #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .init_start(b_init_start), .init_busy(b_init_busy),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .par_err(b_par_err)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = data;
        cyc();
        a_req_valid = 1'b0; a_req_write = 1'b0;
    endtask

    task automatic b_issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = data;
        cyc();
        b_req_valid = 1'b0; b_req_write = 1'b0;
    endtask

    task automatic test_reset();
        int  na = 0;
        int  nb = 0;
        logic bad_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 0", a_req_ready); end
        n_checks++; if (a_init_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_init_busy: got %b expected 1", a_init_busy); end
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", a_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 00", a_rsp_rdata); end
        n_checks++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", a_rsp_err); end
        n_checks++; if (a_par_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_par_err: got %b expected 0", a_par_err); end
        rst_n = 1'b1;
        for (int n = 1; n <= 400 && (na == 0 || nb == 0); n++) begin
            cyc();
            if (a_init_busy && a_req_ready) bad_ready = 1'b1;
            if (na == 0 && a_init_busy === 1'b0) na = n;
            if (nb == 0 && b_init_busy === 1'b0) nb = n;
        end
        n_checks++; if (na != 256) begin n_fail++; $display("[TB] FAIL init_len_256: got %0d edges expected 256", na); end
        n_checks++; if (nb != 200) begin n_fail++; $display("[TB] FAIL init_len_200: got %0d edges expected 200", nb); end
        n_checks++; if (bad_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_during_init: got %b expected 0", bad_ready); end
    endtask

    task automatic test_read_after_init();
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL run_req_ready: got %b expected 1", a_req_ready); end
        a_issue(1'b0, 8'hFF, 8'h00);
        n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_ff_valid: got %b expected 1", a_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rd_ff_data: got %h expected 00", a_rsp_rdata); end
        n_checks++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_ff_err: got %b expected 0", a_rsp_err); end
        n_checks++; if (a_par_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_ff_par: got %b expected 0", a_par_err); end
    endtask

    task automatic test_write_read();
        a_issue(1'b1, 8'h10, 8'hA5);
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL write_no_rsp: got %b expected 0", a_rsp_valid); end
        a_issue(1'b0, 8'h10, 8'h00);
        n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_rd_valid: got %b expected 1", a_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== 8'hA5) begin n_fail++; $display("[TB] FAIL wr_rd_data: got %h expected a5", a_rsp_rdata); end
        cyc();
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rd_single: got %b expected 0", a_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wdat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       s_v  [8];
        logic [7:0] s_d  [8];
        logic       exp_v;
        for (int i = 0; i < 4; i++) b_issue(1'b1, 8'(i), wdat[i]);
        for (int j = 0; j < 8; j++) begin
            b_req_valid = (j < 4); b_req_write = 1'b0; b_req_addr = 8'(j);
            cyc();
            s_v[j] = b_rsp_valid; s_d[j] = b_rsp_rdata;
        end
        b_req_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_v = (j >= 2 && j <= 5);
            n_checks++;
            if (s_v[j] !== exp_v) begin n_fail++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected %b", j, s_v[j], exp_v); end
            if (exp_v) begin
                n_checks++;
                if (s_d[j] !== wdat[j-2]) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", j, s_d[j], wdat[j-2]); end
            end
        end
    endtask

    task automatic test_out_of_range();
        b_issue(1'b1, 8'hC7, 8'h3C);
        b_issue(1'b1, 8'hC8, 8'h5A);
        b_issue(1'b0, 8'hC8, 8'h00);
        b_issue(1'b0, 8'hC7, 8'h00);
        cyc();
        n_checks++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_valid: got %b expected 1", b_rsp_valid); end
        n_checks++; if (b_rsp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_err: got %b expected 1", b_rsp_err); end
        n_checks++; if (b_rsp_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL oor_data: got %h expected 00", b_rsp_rdata); end
        n_checks++; if (b_par_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_par: got %b expected 0", b_par_err); end
        cyc();
        n_checks++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL edge_valid: got %b expected 1", b_rsp_valid); end
        n_checks++; if (b_rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL edge_err: got %b expected 0", b_rsp_err); end
        n_checks++; if (b_rsp_rdata !== 8'h3C) begin n_fail++; $display("[TB] FAIL edge_data: got %h expected 3c", b_rsp_rdata); end
    endtask

    task automatic test_init_start();
        int n = 0;
        a_issue(1'b1, 8'h05, 8'h77);
        a_init_start = 1'b1;
        cyc();
        a_init_start = 1'b0;
        while (a_req_ready === 1'b0 && n < 400) begin
            n++;
            a_init_start = (n == 100);
            cyc();
        end
        a_init_start = 1'b0;
        n_checks++; if (n != 256) begin n_fail++; $display("[TB] FAIL clear_len: got %0d cycles expected 256", n); end
        a_issue(1'b0, 8'h05, 8'h00);
        n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_rd_valid: got %b expected 1", a_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL clear_rd_data: got %h expected 00", a_rsp_rdata); end
    endtask

    task automatic test_inflight_clear();
        int n = 0;
        b_issue(1'b1, 8'h00, 8'h66);
        b_issue(1'b0, 8'h00, 8'h00);
        b_init_start = 1'b1;
        cyc();
        b_init_start = 1'b0;
        n_checks++; if (b_init_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL inflight_busy: got %b expected 1", b_init_busy); end
        cyc();
        n_checks++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL inflight_valid: got %b expected 1", b_rsp_valid); end
        n_checks++; if (b_rsp_rdata !== 8'h66) begin n_fail++; $display("[TB] FAIL inflight_data: got %h expected 66", b_rsp_rdata); end
        while (b_init_busy === 1'b1 && n < 400) begin n++; cyc(); end
        n_checks++; if (b_init_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL inflight_done: got %b expected 0", b_init_busy); end
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        a_issue(1'b1, 8'h20, 8'h0F);
        u_a.mem[8'h20] = u_a.mem[8'h20] ^ 9'h001;
        a_issue(1'b0, 8'h20, 8'h00);
        n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL par_valid: got %b expected 1", a_rsp_valid); end
        n_checks++; if (a_par_err !== 1'b1) begin n_fail++; $display("[TB] FAIL par_flag: got %b expected 1", a_par_err); end
        n_checks++; if (a_rsp_rdata !== 8'h0E) begin n_fail++; $display("[TB] FAIL par_data: got %h expected 0e", a_rsp_rdata); end
        a_issue(1'b0, 8'h10, 8'h00);
        n_checks++; if (a_par_err !== 1'b0) begin n_fail++; $display("[TB] FAIL par_clean: got %b expected 0", a_par_err); end
    endtask
`endif

    task automatic test_reset_mid_read();
        logic seen = 1'b0;
        b_issue(1'b0, 8'h03, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", b_rsp_valid); end
        for (int i = 0; i < 12; i++) begin
            if (i == 3) rst_n = 1'b1;
            cyc();
            if (b_rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_discard: got %b expected 0", seen); end
        n_checks++; if (b_init_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_reinit: got %b expected 1", b_init_busy); end
    endtask

    initial begin
        test_reset();
        test_read_after_init();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_init_start();
        test_inflight_clear();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
